pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline; drives IF/ID (hold, flush), PC write-enable, ID/EX bubble/hold.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/md_stall_timer.sv | 40 ++++
 rtl/pipe_hazard_ctrl_chk.sv | 14 +
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encoding, the zero-register index, the hazard action priority
// encoding and the load-use detection helper.
package pipe_ctrl_pkg;

  // Sequencer states: normal issue or frozen behind a multi-cycle mul/div
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } ctrl_state_e;

  // Register $0 is hard-wired to zero, so a load into it never creates a hazard
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Flush/stall actions in RUN, numbered from highest to lowest priority
  typedef enum logic [2:0] {
    ACT_MD_START  = 3'd0,
    ACT_BRANCH    = 3'd1,
    ACT_LOAD_USE  = 3'd2,
    ACT_JUMP      = 3'd3,
    ACT_NONE      = 3'd4
  } hazard_act_e;

  // A load in EX whose destination feeds a source of the instruction in ID
  function automatic logic load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    logic w_hit;
    w_hit = (ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt));
    return ex_mem_read & (ex_rt != REG_ZERO) & w_hit;
  endfunction

endpackage

// File: rtl/md_stall_timer.sv
// Load/decrement occupancy counter for a multi-cycle mul/div op.
// Loaded when the op enters EX, decremented while the front end is frozen;
// o_done is a registered one-cycle pulse issued the cycle after the count
// has been observed at zero while decrementing.
module md_stall_timer #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero,
  output logic         o_done
);

  logic [W-1:0] r_cnt;
  logic         r_done;

  assign o_zero = (r_cnt == {W{1'b0}});
  assign o_done = r_done;

  // Counter and done pulse; reset clears both so an aborted op never signals done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= {W{1'b0}};
      r_done <= 1'b0;
    end else begin
      r_done <= i_dec & o_zero;
      if (i_load) begin
        r_cnt <= i_load_val;
      end else if (i_dec && !o_zero) begin
        r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl_chk.sv
// Protocol checker for the hazard controller inputs: a mul/div op and a
// taken branch can never both be resolving in EX in the same cycle.
module pipe_hazard_ctrl_chk (
  input logic Clk,
  input logic Rst,
  input logic ex_md_start,
  input logic ex_branch_taken
);

  // EX holds a single instruction, so it is either a mul/div or a branch
  a_md_not_branch : assert property (@(posedge Clk) disable iff (Rst)
    !(ex_md_start && ex_branch_taken));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// In RUN the control outputs are a prioritised combinational decode of the
// hazard inputs (mul/div start > taken branch > load-use > jump). While a
// mul/div occupies EX the front end and ID/EX are frozen for MD_CYCLES-1
// cycles, then md_done pulses for one cycle.
// Optional build macro: PIPE_PERF_CNT_EN adds stall_cycles/flush_count.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_Jump,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        ex_md_start,
  output logic        pc_write,
  output logic        hazard,
  output logic        if_flush,
  output logic        ex_bubble,
  output logic        id_ex_hold,
  output logic        md_busy,
  output logic        md_done
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam int CNT_W = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

  ctrl_state_e r_state;
  hazard_act_e w_act;
  logic        w_lu;
  logic        w_md_load;
  logic        w_md_dec;
  logic        w_md_zero;

  assign w_lu      = load_use(ex_MemRead, ex_rt, id_rs, id_rt, id_uses_rt);
  assign w_md_load = (r_state == RUN) & ex_md_start;
  assign w_md_dec  = (r_state == MD_WAIT);

  md_stall_timer #(
    .W (CNT_W)
  ) u_md_timer (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_load     (w_md_load),
    .i_load_val (MD_LOAD),
    .i_dec      (w_md_dec),
    .o_zero     (w_md_zero),
    .o_done     (md_done)
  );

  // Sequencer state: enter MD_WAIT on a mul/div start, leave when the timer expires
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     r_state <= ex_md_start ? MD_WAIT : RUN;
        MD_WAIT: r_state <= w_md_zero ? RUN : MD_WAIT;
        default: r_state <= RUN;
      endcase
    end
  end

  // Pick the single highest-priority hazard action for this cycle
  always_comb begin
    w_act = ACT_NONE;
    if (ex_md_start) begin
      w_act = ACT_MD_START;
    end else if (ex_branch_taken) begin
      w_act = ACT_BRANCH;
    end else if (w_lu) begin
      w_act = ACT_LOAD_USE;
    end else if (id_Jump) begin
      w_act = ACT_JUMP;
    end else begin
      w_act = ACT_NONE;
    end
  end

  // Decode state and action into pipeline control; MD_WAIT ignores all hazard inputs
  always_comb begin
    pc_write   = 1'b1;
    hazard     = 1'b0;
    if_flush   = 1'b0;
    ex_bubble  = 1'b0;
    id_ex_hold = 1'b0;
    md_busy    = 1'b0;
    case (r_state)
      RUN: begin
        case (w_act)
          ACT_BRANCH: begin
            if_flush  = 1'b1;
            ex_bubble = 1'b1;
          end
          ACT_LOAD_USE: begin
            // a jump sitting in ID is held here and flushes once the load leaves EX
            hazard    = 1'b1;
            pc_write  = 1'b0;
            ex_bubble = 1'b1;
          end
          ACT_JUMP: begin
            if_flush = 1'b1;
          end
          ACT_MD_START: begin
            pc_write = 1'b1;
          end
          ACT_NONE: begin
            pc_write = 1'b1;
          end
          default: begin
            pc_write = 1'b1;
          end
        endcase
      end
      MD_WAIT: begin
        pc_write   = 1'b0;
        hazard     = 1'b1;
        id_ex_hold = 1'b1;
        md_busy    = 1'b1;
      end
      default: begin
        pc_write = 1'b1;
      end
    endcase
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

  // Performance counters: cycles with the PC frozen and cycles flushing IF/ID
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      r_stall_cycles <= r_stall_cycles + {31'd0, ~pc_write};
      r_flush_count  <= r_flush_count + {31'd0, if_flush};
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MD_CYCLES=4).
// Observed output vector order: {pc_write,hazard,if_flush,ex_bubble,id_ex_hold,md_busy,md_done}
module tb_pipe_hazard_ctrl;

  logic        Clk;
  logic        Rst;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_Jump;
  logic        ex_MemRead;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        ex_md_start;
  logic        pc_write;
  logic        hazard;
  logic        if_flush;
  logic        ex_bubble;
  logic        id_ex_hold;
  logic        md_busy;
  logic        md_done;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int n_cmp;
  int n_err;

  pipe_hazard_ctrl #(.MD_CYCLES(4)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_Jump         (id_Jump),
    .ex_MemRead      (ex_MemRead),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_md_start     (ex_md_start),
    .pc_write        (pc_write),
    .hazard          (hazard),
    .if_flush        (if_flush),
    .ex_bubble       (ex_bubble),
    .id_ex_hold      (id_ex_hold),
    .md_busy         (md_busy),
    .md_done         (md_done)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  pipe_hazard_ctrl_chk u_chk (
    .Clk             (Clk),
    .Rst             (Rst),
    .ex_md_start     (ex_md_start),
    .ex_branch_taken (ex_branch_taken)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Apply one cycle of inputs just after the falling edge
  task automatic drive(input logic md, input logic br, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic jmp);
    @(negedge Clk);
    ex_md_start     = md;
    ex_branch_taken = br;
    ex_MemRead      = mr;
    ex_rt           = ert;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = urt;
    id_Jump         = jmp;
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {pc_write, hazard, if_flush, ex_bubble, id_ex_hold, md_busy, md_done};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    Rst   = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    Rst = 1'b0;
    check("reset_idle", 7'b1000000);

    // load-use on rs: one stall cycle, then normal once the load leaves EX
    drive(1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 5'd7, 1'b1, 1'b0);
    check("lu_rs_stall", 7'b0101000);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd2, 5'd7, 1'b1, 1'b0);
    check("lu_rs_release", 7'b1000000);

    // load to $0 and rt match without rt use never stall
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    check("lu_reg_zero", 7'b1000000);
    drive(1'b0, 1'b0, 1'b1, 5'd3, 5'd5, 5'd3, 1'b0, 1'b0);
    check("lu_rt_unused", 7'b1000000);
    drive(1'b0, 1'b0, 1'b1, 5'd3, 5'd5, 5'd3, 1'b1, 1'b0);
    check("lu_rt_used", 7'b0101000);

    // priority: branch over load-use over jump
    drive(1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1);
    check("branch_over_lu_jump", 7'b1011000);
    drive(1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1);
    check("lu_over_jump", 7'b0101000);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1);
    check("jump_flush", 7'b1010000);

    // mul/div: start cycle is normal RUN, 3 frozen cycles with hazard inputs ignored, then done
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("md_start", 7'b1000000);
    drive(1'b0, 1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1);
    check("md_wait_1", 7'b0100110);
    drive(1'b0, 1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1);
    check("md_wait_2", 7'b0100110);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("md_wait_3", 7'b0100110);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("md_done_pulse", 7'b1000001);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("md_after_done", 7'b1000000);

    // abort by reset in 2nd MD_WAIT cycle; start held high in MD_WAIT is ignored
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("md2_start", 7'b1000000);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("md2_wait_1", 7'b0100110);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    Rst = 1'b1;
    #1;
    check("md2_wait_2_rst", 7'b0100110);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    Rst = 1'b0;
    #1;
    check("rst_abort", 7'b1000000);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("rst_no_done", 7'b1000000);

    // one load stall followed by one jump flush
    drive(1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
    check("perf_lu", 7'b0101000);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("perf_jump", 7'b1010000);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("perf_idle", 7'b1000000);
`ifdef PIPE_PERF_CNT_EN
    check32("stall_cycles", stall_cycles, 32'd1);
    check32("flush_count", flush_count, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
